// File: rtl/tinyalu_arbiter.sv
// tinyalu_arbiter
//
// Round-robin arbiter and sequencer that lets NUM_REQ requesters share one
// TinyALU. A request is accepted in IDLE, its operands and opcode are latched
// and driven onto the ALU with the start/done handshake. The result goes back
// to the requester that issued it, together with a status code.
// Illegal opcodes are answered at once and never reach the ALU.
//
// Parameters
//   NUM_REQ     number of requesters (2..8)
//   TIMEOUT     BUSY cycles without alu_done before the operation is aborted (2..255)
//
// Ports
//   clk         single clock, all logic on posedge
//   reset_n     asynchronous active-low reset
//   req         per-requester request level
//   req_A/B     8-bit operand slices, slice i belongs to requester i
//   req_op      3-bit opcode slices
//   gnt         one-hot acceptance pulse
//   rsp_valid   one-hot completion pulse
//   rsp_result  16-bit result, valid with rsp_valid
//   rsp_status  00 ok, 01 timeout, 10 illegal opcode, valid with rsp_valid
//   alu_A/B     ALU operands
//   alu_op      ALU opcode
//   alu_start   ALU start, held high for the whole operation
//   alu_done    ALU done
//   alu_result  ALU result
module tinyalu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_A,
    input  logic [8*NUM_REQ-1:0]   req_B,
    input  logic [3*NUM_REQ-1:0]   req_op,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [15:0]            rsp_result,
    output logic [1:0]             rsp_status,
    output logic [7:0]             alu_A,
    output logic [7:0]             alu_B,
    output logic [2:0]             alu_op,
    output logic                   alu_start,
    input  logic                   alu_done,
    input  logic [15:0]            alu_result
);

    localparam int IDX_W = $clog2(NUM_REQ);

    localparam logic [2:0]       OP_NOOP    = 3'b000;
    localparam logic [2:0]       OP_MUL     = 3'b100;
    localparam logic [1:0]       ST_OK      = 2'b00;
    localparam logic [1:0]       ST_TIMEOUT = 2'b01;
    localparam logic [1:0]       ST_ILLEGAL = 2'b10;
    localparam logic [IDX_W-1:0] LAST_INIT  = IDX_W'(NUM_REQ - 1);
    localparam logic [7:0]       TMO_LIMIT  = 8'(TIMEOUT);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [15:0]          rsp_result_q, rsp_result_d;
    logic [1:0]           rsp_status_q, rsp_status_d;
    logic [7:0]           alu_A_q, alu_A_d;
    logic [7:0]           alu_B_q, alu_B_d;
    logic [2:0]           alu_op_q, alu_op_d;
    logic                 alu_start_q, alu_start_d;
    logic [7:0]           cnt_q, cnt_d;

    // Round-robin search results
    logic                 req_found;
    logic [IDX_W-1:0]     winner;
    int                   cand;
    logic [IDX_W-1:0]     cand_idx;
    logic [2:0]           win_op;
    logic [7:0]           win_A;
    logic [7:0]           win_B;
    logic                 win_legal;
    logic [NUM_REQ-1:0]   win_onehot;
    logic                 busy_end;

    // Round-robin pick: scan from last+1 upwards, wrapping at NUM_REQ, so the
    // most recently served requester is always considered last.
    always_comb begin
        req_found = 1'b0;
        winner    = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = int'(last_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!req_found && req[cand_idx]) begin
                req_found = 1'b1;
                winner    = cand_idx;
            end
        end
    end

    assign win_op     = req_op[3*int'(winner) +: 3];
    assign win_A      = req_A[8*int'(winner) +: 8];
    assign win_B      = req_B[8*int'(winner) +: 8];
    assign win_legal  = (win_op <= OP_MUL);
    assign win_onehot = NUM_REQ'(1) << winner;

    // A no_op finishes on the first BUSY edge regardless of alu_done; a real
    // done beats a timeout on the same edge because it is checked first below.
    assign busy_end = (alu_op_q == OP_NOOP) || alu_done || (cnt_q == TMO_LIMIT);

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_q       <= LAST_INIT;
            idx_q        <= '0;
            gnt_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_status_q <= ST_OK;
            alu_A_q      <= '0;
            alu_B_q      <= '0;
            alu_op_q     <= OP_NOOP;
            alu_start_q  <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            idx_q        <= idx_d;
            gnt_q        <= gnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_status_q <= rsp_status_d;
            alu_A_q      <= alu_A_d;
            alu_B_q      <= alu_B_d;
            alu_op_q     <= alu_op_d;
            alu_start_q  <= alu_start_d;
            cnt_q        <= cnt_d;
        end
    end

    // Next-state logic; an illegal opcode is answered from IDLE and never
    // enters BUSY.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_found && win_legal) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (busy_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values. gnt and rsp_valid are pulses and default
    // to zero; everything else holds, so the ALU operands keep their last
    // values after an operation ends.
    always_comb begin
        last_d       = last_q;
        idx_d        = idx_q;
        gnt_d        = '0;
        rsp_valid_d  = '0;
        rsp_result_d = rsp_result_q;
        rsp_status_d = rsp_status_q;
        alu_A_d      = alu_A_q;
        alu_B_d      = alu_B_q;
        alu_op_d     = alu_op_q;
        alu_start_d  = alu_start_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_found) begin
                    last_d = winner;
                    idx_d  = winner;
                    gnt_d  = win_onehot;
                    if (win_legal) begin
                        alu_A_d     = win_A;
                        alu_B_d     = win_B;
                        alu_op_d    = win_op;
                        alu_start_d = 1'b1;
                        cnt_d       = 8'd1;
                    end else begin
                        rsp_valid_d  = win_onehot;
                        rsp_result_d = '0;
                        rsp_status_d = ST_ILLEGAL;
                    end
                end
            end
            BUSY: begin
                if (busy_end) begin
                    alu_start_d = 1'b0;
                    cnt_d       = '0;
                    rsp_valid_d = NUM_REQ'(1) << idx_q;
                    if (alu_op_q == OP_NOOP) begin
                        rsp_result_d = '0;
                        rsp_status_d = ST_OK;
                    end else if (alu_done) begin
                        rsp_result_d = alu_result;
                        rsp_status_d = ST_OK;
                    end else begin
                        rsp_result_d = '0;
                        rsp_status_d = ST_TIMEOUT;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    assign gnt        = gnt_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_status = rsp_status_q;
    assign alu_A      = alu_A_q;
    assign alu_B      = alu_B_q;
    assign alu_op     = alu_op_q;
    assign alu_start  = alu_start_q;

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// tb_tinyalu_arbiter
//
// Bench for tinyalu_arbiter with four requesters and TIMEOUT=15. A
// TinyALU-like peer answers the start/done handshake. Every cycle the outputs
// are compared with a transaction-level reference: the round-robin winner
// follows from the request mask, and the response edge is the acceptance edge
// plus the opcode latency. The expected result is the arithmetic value of the
// requester's own operands.
module tb_tinyalu_arbiter;

    localparam int NR = 4;
    localparam int TO = 15;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NR-1:0]     req;
    logic [8*NR-1:0]   req_A;
    logic [8*NR-1:0]   req_B;
    logic [3*NR-1:0]   req_op;
    logic [NR-1:0]     gnt;
    logic [NR-1:0]     rsp_valid;
    logic [15:0]       rsp_result;
    logic [1:0]        rsp_status;
    logic [7:0]        alu_A;
    logic [7:0]        alu_B;
    logic [2:0]        alu_op;
    logic              alu_start;
    logic              alu_done = 1'b0;
    logic [15:0]       alu_result = 16'h0000;

    tinyalu_arbiter #(
        .NUM_REQ (NR),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .req_A      (req_A),
        .req_B      (req_B),
        .req_op     (req_op),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .rsp_status (rsp_status),
        .alu_A      (alu_A),
        .alu_B      (alu_B),
        .alu_op     (alu_op),
        .alu_start  (alu_start),
        .alu_done   (alu_done),
        .alu_result (alu_result)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Requester agents
    bit         pending [NR];
    logic [7:0] aArr    [NR];
    logic [7:0] bArr    [NR];
    logic [2:0] opArr   [NR];
    bit         sticky    = 1'b0;
    bit         randomArm = 1'b0;
    bit         neverDone = 1'b0;

    // Reference model state
    bit          mBusy;
    int          mLast;
    int          mDoneEdge;
    int          mIdx;
    logic [15:0] mRes;
    logic [1:0]  mSt;
    logic [7:0]  mAluA;
    logic [7:0]  mAluB;
    logic [2:0]  mAluOp;
    int          gntLog[$];

    function automatic logic [15:0] refResult(logic [2:0] op, logic [7:0] a, logic [7:0] b);
        case (op)
            3'b001:  return 16'(a) + 16'(b);
            3'b010:  return {8'h00, a & b};
            3'b011:  return {8'h00, a ^ b};
            3'b100:  return 16'(a) * 16'(b);
            default: return 16'h0000;
        endcase
    endfunction

    // Acceptance-to-response latency in cycles
    function automatic int expLatency(logic [2:0] op);
        if (op == 3'b000) return 1;
        if (neverDone)    return TO;
        if (op == 3'b100) return 4;
        return 2;
    endfunction

    function automatic int rrPick(logic [NR-1:0] m, int last);
        int c;
        for (int k = 1; k <= NR; k++) begin
            c = (last + k) % NR;
            if (m[c]) return c;
        end
        return -1;
    endfunction

    // TinyALU-like peer: single-cycle ops raise done on the second cycle of
    // start, mul on the fourth; with neverDone it stays silent.
    int startCnt = 0;
    always @(negedge clk) begin
        if (alu_start) begin
            startCnt = startCnt + 1;
            if (!neverDone && startCnt == ((alu_op == 3'b100) ? 4 : 2)) begin
                alu_done   = 1'b1;
                alu_result = refResult(alu_op, alu_A, alu_B);
            end else begin
                alu_done   = 1'b0;
                alu_result = 16'h0000;
            end
        end else begin
            startCnt   = 0;
            alu_done   = 1'b0;
            alu_result = 16'h0000;
        end
    end

    task automatic checkEq(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic armReq(int i, logic [2:0] op, logic [7:0] a, logic [7:0] b);
        pending[i] = 1'b1;
        opArr[i]   = op;
        aArr[i]    = a;
        bArr[i]    = b;
    endtask

    task automatic clearReqs();
        for (int i = 0; i < NR; i++) pending[i] = 1'b0;
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < NR; i++) begin
            req[i]            = pending[i];
            req_A[8*i +: 8]   = aArr[i];
            req_B[8*i +: 8]   = bArr[i];
            req_op[3*i +: 3]  = opArr[i];
        end
    endtask

    task automatic checkOutput(logic [NR-1:0] expGnt, logic [NR-1:0] expRv,
                               logic [15:0] expRes, logic [1:0] expSt);
        checkEq("gnt", 32'(gnt), 32'(expGnt));
        checkEq("rsp_valid", 32'(rsp_valid), 32'(expRv));
        checkEq("alu_start", 32'(alu_start), 32'(mBusy));
        if (expRv != '0) begin
            checkEq("rsp_result", 32'(rsp_result), 32'(expRes));
            checkEq("rsp_status", 32'(rsp_status), 32'(expSt));
        end
        checkEq("alu_A", 32'(alu_A), 32'(mAluA));
        checkEq("alu_B", 32'(alu_B), 32'(mAluB));
        checkEq("alu_op", 32'(alu_op), 32'(mAluOp));
    endtask

    // One clock: the reference decides what the edge just passed must have
    // produced, the outputs are compared, then requesters react.
    task automatic stepCycle();
        logic [NR-1:0] expGnt;
        logic [NR-1:0] expRv;
        logic [15:0]   expRes;
        logic [1:0]    expSt;
        int            w;
        @(negedge clk);
        cyc++;
        expGnt = '0;
        expRv  = '0;
        expRes = 16'h0000;
        expSt  = 2'b00;
        w      = -1;
        if (mBusy) begin
            if (cyc == mDoneEdge) begin
                expRv  = NR'(1) << mIdx;
                expRes = mRes;
                expSt  = mSt;
                mBusy  = 1'b0;
            end
        end else if (req != '0) begin
            w      = rrPick(req, mLast);
            mLast  = w;
            expGnt = NR'(1) << w;
            if (opArr[w] > 3'd4) begin
                expRv  = expGnt;
                expRes = 16'h0000;
                expSt  = 2'b10;
            end else begin
                mBusy     = 1'b1;
                mIdx      = w;
                mDoneEdge = cyc + expLatency(opArr[w]);
                mAluA     = aArr[w];
                mAluB     = bArr[w];
                mAluOp    = opArr[w];
                if (neverDone && opArr[w] != 3'b000) begin
                    mRes = 16'h0000;
                    mSt  = 2'b01;
                end else begin
                    mRes = refResult(opArr[w], aArr[w], bArr[w]);
                    mSt  = 2'b00;
                end
            end
        end
        checkOutput(expGnt, expRv, expRes, expSt);
        for (int i = 0; i < NR; i++) if (gnt[i]) gntLog.push_back(i);
        if (w >= 0 && !sticky) pending[w] = 1'b0;
        if (randomArm) begin
            for (int i = 0; i < NR; i++) begin
                if (!pending[i] && $urandom_range(3) == 0)
                    armReq(i, 3'($urandom_range(7)), 8'($urandom), 8'($urandom));
            end
        end
        applyStimulus();
    endtask

    task automatic runCycles(int n);
        repeat (n) stepCycle();
    endtask

    task automatic runUntilGrants(int n, int budget);
        while (gntLog.size() < n && budget > 0) begin
            stepCycle();
            budget--;
        end
        checkEq("grant_budget", 32'(gntLog.size() >= n), 32'd1);
    endtask

    function automatic int logAt(int k);
        return (gntLog.size() > k) ? gntLog[k] : -1;
    endfunction

    // Assert reset at a negedge, confirm everything is back at reset values
    // at once, hold a few cycles, then release and restart the reference.
    task automatic doReset();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        clearReqs();
        applyStimulus();
        #1;
        checkEq("rst_gnt", 32'(gnt), 32'd0);
        checkEq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkEq("rst_rsp_result", 32'(rsp_result), 32'd0);
        checkEq("rst_rsp_status", 32'(rsp_status), 32'd0);
        checkEq("rst_alu_A", 32'(alu_A), 32'd0);
        checkEq("rst_alu_B", 32'(alu_B), 32'd0);
        checkEq("rst_alu_op", 32'(alu_op), 32'd0);
        checkEq("rst_alu_start", 32'(alu_start), 32'd0);
        repeat (2) begin
            @(negedge clk);
            checkEq("rst_hold_rsp_valid", 32'(rsp_valid), 32'd0);
            checkEq("rst_hold_alu_start", 32'(alu_start), 32'd0);
        end
        reset_n = 1'b1;
        mBusy   = 1'b0;
        mLast   = NR - 1;
        mAluA   = 8'h00;
        mAluB   = 8'h00;
        mAluOp  = 3'b000;
    endtask

    initial begin
        reset_n = 1'b0;
        for (int i = 0; i < NR; i++) begin
            pending[i] = 1'b0;
            aArr[i]    = 8'h00;
            bArr[i]    = 8'h00;
            opArr[i]   = 3'b000;
        end
        applyStimulus();
        doReset();

        $display("[TB] single add from requester 0");
        armReq(0, 3'b001, 8'h05, 8'h07);
        applyStimulus();
        runCycles(4);

        $display("[TB] mul FF*FF");
        armReq(0, 3'b100, 8'hFF, 8'hFF);
        applyStimulus();
        runCycles(6);

        $display("[TB] four requesters re-requesting continuously");
        doReset();
        gntLog.delete();
        sticky = 1'b1;
        for (int i = 0; i < NR; i++) armReq(i, 3'b001, 8'(i + 1), 8'(3 * i));
        applyStimulus();
        runUntilGrants(6, 60);
        checkEq("rr_order0", 32'(logAt(0)), 32'd0);
        checkEq("rr_order1", 32'(logAt(1)), 32'd1);
        checkEq("rr_order2", 32'(logAt(2)), 32'd2);
        checkEq("rr_order3", 32'(logAt(3)), 32'd3);
        checkEq("rr_order4", 32'(logAt(4)), 32'd0);
        checkEq("rr_order5", 32'(logAt(5)), 32'd1);
        sticky = 1'b0;
        clearReqs();
        applyStimulus();
        runCycles(6);

        $display("[TB] grant to 2, then everyone asks");
        gntLog.delete();
        armReq(2, 3'b011, 8'h3C, 8'h0F);
        applyStimulus();
        runCycles(4);
        for (int i = 0; i < NR; i++) armReq(i, 3'b010, 8'hF0, 8'(8'h11 * i));
        applyStimulus();
        runUntilGrants(2, 20);
        checkEq("rr_after2_first", 32'(logAt(0)), 32'd2);
        checkEq("rr_after2_next", 32'(logAt(1)), 32'd3);
        runCycles(16);

        $display("[TB] illegal opcode from requester 1");
        armReq(1, 3'b110, 8'h12, 8'h34);
        applyStimulus();
        runCycles(3);

        $display("[TB] ALU never answers");
        neverDone = 1'b1;
        armReq(0, 3'b001, 8'h01, 8'h02);
        applyStimulus();
        runCycles(TO + 3);
        neverDone = 1'b0;
        armReq(3, 3'b011, 8'hAA, 8'h55);
        applyStimulus();
        runCycles(4);

        $display("[TB] random traffic");
        randomArm = 1'b1;
        runCycles(400);
        randomArm = 1'b0;
        clearReqs();
        applyStimulus();
        runCycles(8);

        $display("[TB] reset during mul");
        armReq(2, 3'b100, 8'hAB, 8'hCD);
        applyStimulus();
        runCycles(2);
        doReset();
        gntLog.delete();
        for (int i = 0; i < NR; i++) armReq(i, 3'b001, 8'(i), 8'h01);
        applyStimulus();
        runUntilGrants(1, 4);
        checkEq("post_reset_winner", 32'(logAt(0)), 32'd0);
        clearReqs();
        applyStimulus();
        runCycles(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tinyalu_arbiter.md
# tinyalu_arbiter

Round-robin arbiter and sequencer that shares one TinyALU between `NUM_REQ` requesters. Each request is accepted, and its operands and opcode are latched and issued to the ALU with the start/done handshake. The result is returned to the originating requester with a status code. The block sits between the requester agents and the single `tinyalu` instance and is the only driver of the ALU's `A`, `B`, `op` and `start` inputs.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 15: maximum number of BUSY cycles without `alu_done` before the operation is aborted, 2..255.

- `clk`  in  1  single clock; all logic on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  per-requester request level; held until `gnt` is seen.
- `req_A`  in  8*NUM_REQ  operand A, slice i for requester i; stable while `req[i]`.
- `req_B`  in  8*NUM_REQ  operand B, slice i.
- `req_op`  in  3*NUM_REQ  opcode, slice i: 000 no_op, 001 add, 010 and, 011 xor, 100 mul, others illegal.
- `gnt`  out  NUM_REQ  one-hot, one-cycle pulse marking acceptance.
- `rsp_valid`  out  NUM_REQ  one-hot, one-cycle pulse marking completion for requester i.
- `rsp_result`  out  16  result, valid with `rsp_valid`.
- `rsp_status`  out  2  00 ok, 01 timeout, 10 illegal opcode; valid with `rsp_valid`.
- `alu_A`, `alu_B`  out  8 each  ALU operands.
- `alu_op`  out  3  ALU opcode.
- `alu_start`  out  1  ALU start.
- `alu_done`  in  1  ALU done.
- `alu_result`  in  16  ALU result.

## Operation
- FSM states: IDLE, BUSY. Reset state is IDLE.
- **IDLE:**
  - At the posedge where `req` is nonzero, select a winner by round-robin. Search starts at index `last+1` and wraps modulo `NUM_REQ`. After reset `last = NUM_REQ-1`, so requester 0 has highest priority.
  - Latch the winner's A, B and op and the winner index, and update `last`.
  - Assert `gnt[winner]` for exactly one cycle.
  - Legal opcode: go to BUSY, driving `alu_start=1`, `alu_A`/`alu_B`/`alu_op` from the latched values, and the timeout counter at 1.
  - Illegal opcode: stay IDLE. Pulse `rsp_valid[winner]` in the same cycle as `gnt`, with `rsp_status=10` and `rsp_result=0`. The ALU is untouched.
- **BUSY** (`alu_start` held at 1, operands held stable):
  - no_op: at the next posedge, end the operation with `rsp_status=00` and `rsp_result=0`. `alu_done` is ignored.
  - Otherwise, at the posedge where `alu_done=1` is sampled: latch `alu_result`, end the operation with `rsp_status=00`.
  - Otherwise, if the counter equals `TIMEOUT`: end the operation with `rsp_status=01` and `rsp_result=0`.
  - Otherwise, increment the counter.
  - If `alu_done` and the timeout occur at the same edge, `alu_done` wins.
- **Ending an operation:**
  - `alu_start<=0`, `rsp_valid[idx]<=1` for one cycle, state goes to IDLE.
  - `alu_op`/`alu_A`/`alu_B` keep their last values.
- `req` is not sampled in BUSY. Requests arriving during BUSY simply wait.

## Timing
- Reset values: `gnt`=0, `rsp_valid`=0, `rsp_result`=0, `rsp_status`=00, `alu_A`=0, `alu_B`=0, `alu_op`=000, `alu_start`=0, counter 0, `last`=NUM_REQ-1.
- Reset asserted mid-operation: everything returns to reset values immediately. The in-flight request gets no response, and `alu_start` drops asynchronously.
- Request sampled at edge k:
  - `gnt` and `alu_start` are high from edge k to edge k+1.
  - If done is sampled at edge d, `rsp_valid` is high from d to d+1.
- Latencies from acceptance edge to `rsp_valid`:
  - no_op: 1 cycle.
  - Single-cycle ALU op: 2 cycles.
  - mul: 4 cycles with the standard TinyALU.
  - Timeout: `TIMEOUT` cycles.
- `alu_start` is low for at least one cycle between consecutive operations, because the earliest new acceptance is the edge following completion.
- Back-to-back throughput is one operation per (latency+1) cycles.
- A requester must drop `req` in the cycle after `gnt`. Keeping it high is a new request.

## Test plan
- Single requester 0, add A=8'h05 B=8'h07 -> `gnt[0]` one cycle; `rsp_valid[0]` 2 cycles later; `rsp_result`=16'h000C, status 00.
- mul A=8'hFF B=8'hFF -> `rsp_result`=16'hFE01, status 00; `alu_start` held high until done is sampled, then low for at least one cycle.
- All four requesters assert simultaneously and continuously re-request -> grants ordered 0,1,2,3,0,1 with no starvation. Repeat after a grant to 2 and check that 3 goes next.
- Requester 1 op=3'b110 -> `gnt[1]` and `rsp_valid[1]` in the same cycle; status 10, result 0; `alu_start` never rises.
- ALU model never asserts done (TIMEOUT=15) -> `rsp_valid` 15 cycles after acceptance with status 01; `alu_start` drops; the next request is served normally.
- Assert `reset_n`=0 during a mul in BUSY -> all outputs at reset values immediately, no `rsp_valid`; after release requester 0 wins first.
